branch_resolve_unit: RTL
========================

// Module: branch_resolve_unit
// PURPOSE
//  Consumer side of the ALU flag path. Latches NZCV from flag-setting ALU ops (Z from the
//  64-bit zero detector) and resolves B, CBZ, CBNZ and B.cond in EX. On a taken branch it
//  issues a registered redirect to fetch over a valid/ready handshake and flushes the
//  younger IF/ID instructions. It sits between the EX-stage ALU and the PC/fetch logic.
// PARAMETERS
//  WIDTH         64  datapath/PC width
//  FLUSH_CYCLES  1   extra cycles flush stays high after the redirect is accepted (0 allowed)
// PORTS
//  clk             in   1      clock, rising edge
//  reset           in   1      asynchronous, active-high reset
//  zero_in         in   1      Z from zero detector for the current EX result
//  neg_in          in   1      N = result[WIDTH-1]
//  carry_in        in   1      C from adder
//  ovf_in          in   1      V from adder
//  set_flags       in   1      EX op is ADDS/SUBS/ANDS: latch {N,Z,C,V} at the edge
//  br_valid        in   1      branch in EX this cycle
//  br_type         in   2      00 B, 01 CBZ, 10 CBNZ, 11 B.cond
//  br_cond         in   4      ARM condition code, used by B.cond only
//  br_target       in   WIDTH  computed target PC
//  redirect_ready  in   1      fetch accepts the redirect
//  flags_q         out  4      latched {N,Z,C,V}
//  redirect_valid  out  1      redirect_pc is valid
//  redirect_pc     out  WIDTH  new fetch PC
//  flush           out  1      squash IF/ID instructions
//  stall           out  1      hold pipeline while the redirect is pending
// BEHAVIOUR
//  - Reset (async, any state): flags_q=0, redirect_valid=0, redirect_pc=0, flush=0,
//    stall=0, state=IDLE, flush counter=0.
//  - Flag register: flags_q <= {neg_in,zero_in,carry_in,ovf_in} on an edge with set_flags=1;
//    otherwise it holds. Updates in every state, including during a flush.
//  - Taken decision (combinational, in IDLE with br_valid=1):
//    - B: always taken.
//    - CBZ: taken iff zero_in=1. CBNZ: taken iff zero_in=0. Both use live zero_in, not flags_q.
//    - B.cond uses flags_q (pre-update value even if set_flags is high this cycle):
//      EQ 0000 Z; NE 0001 !Z; CS 0010 C; CC 0011 !C; MI 0100 N; PL 0101 !N;
//      VS 0110 V; VC 0111 !V; HI 1000 C&!Z; LS 1001 !C|Z; GE 1010 N==V; LT 1011 N!=V;
//      GT 1100 !Z&(N==V); LE 1101 Z|(N!=V); AL 1110/1111 taken.
//  - FSM:
//    - IDLE: taken -> latch redirect_pc=br_target, go to REDIRECT. Not taken -> stay; no outputs change.
//    - REDIRECT: redirect_valid=1, flush=1, stall=1. redirect_pc is stable until accepted.
//      Transfer occurs on an edge with redirect_ready=1.
//      Then go to FLUSH with counter=FLUSH_CYCLES, or to IDLE if FLUSH_CYCLES=0.
//    - FLUSH: flush=1, redirect_valid=0, stall=0. Counter decrements each cycle.
//      Go to IDLE when the counter reaches 1 (exactly FLUSH_CYCLES cycles).
//  - Latency: taken branch in cycle T -> redirect_valid=1 and flush=1 from cycle T+1.
//    With redirect_ready already high at T+1, the FSM is back in IDLE at T+2+FLUSH_CYCLES.
//  - br_valid outside IDLE is ignored (that instruction is wrong-path and is being flushed).
//  - redirect_ready outside REDIRECT is ignored.
//  - All outputs are registered or decoded from registered state; no input->output
//    combinational path.
// TESTING
//  1 SUBS 5-5 (zero_in=1,C=1) with set_flags, then B.cond EQ -> flags_q=0110; taken;
//    redirect_pc=target at T+1.
//  2 CBZ with zero_in=0 -> no redirect/flush. CBNZ with zero_in=0, target 0x40 ->
//    redirect_valid=1, redirect_pc=0x40.
//  3 redirect_ready low 3 cycles -> redirect_valid/stall/flush held 3 cycles, redirect_pc
//    stable; accepted 4th cycle; flush for FLUSH_CYCLES more.
//  4 Sweep all 16 cond codes over all 16 NZCV values -> taken matches the table
//    (e.g. N=1,V=0: GE not taken, LT taken).
//  5 set_flags with new NZCV in the same cycle as B.cond -> decision uses old flags_q;
//    flags_q shows new value next cycle.
//  6 Assert reset while in REDIRECT -> all outputs 0 immediately, without waiting for a
//    clock edge; a branch after reset is resolved normally.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: latches NZCV, decides B/CBZ/CBNZ/B.cond and issues a
// registered fetch redirect over valid/ready, then flushes the younger IF/ID slots.
module branch_resolve_unit #(
  parameter int unsigned WIDTH        = 64,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             zero_in,
  input  logic             neg_in,
  input  logic             carry_in,
  input  logic             ovf_in,
  input  logic             set_flags,
  input  logic             br_valid,
  input  logic [1:0]       br_type,
  input  logic [3:0]       br_cond,
  input  logic [WIDTH-1:0] br_target,
  input  logic             redirect_ready,
  output logic [3:0]       flags_q,
  output logic             redirect_valid,
  output logic [WIDTH-1:0] redirect_pc,
  output logic             flush,
  output logic             stall
);

  localparam int unsigned CntW = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {
    Idle     = 2'd0,
    Redirect = 2'd1,
    Flush    = 2'd2
  } stateT;

  stateT            state, stateNext;
  logic [CntW-1:0]  cnt, cntNext;
  logic [WIDTH-1:0] pcNext;
  logic             validNext, flushNext, stallNext;
  logic             condHolds, taken;

  // B.cond evaluated against the flags latched before this cycle's edge
  always_comb begin
    condHolds = 1'b0;
    case (br_cond)
      4'b0000: condHolds = flags_q[2];
      4'b0001: condHolds = !flags_q[2];
      4'b0010: condHolds = flags_q[1];
      4'b0011: condHolds = !flags_q[1];
      4'b0100: condHolds = flags_q[3];
      4'b0101: condHolds = !flags_q[3];
      4'b0110: condHolds = flags_q[0];
      4'b0111: condHolds = !flags_q[0];
      4'b1000: condHolds = flags_q[1] && !flags_q[2];
      4'b1001: condHolds = !flags_q[1] || flags_q[2];
      4'b1010: condHolds = (flags_q[3] == flags_q[0]);
      4'b1011: condHolds = (flags_q[3] != flags_q[0]);
      4'b1100: condHolds = !flags_q[2] && (flags_q[3] == flags_q[0]);
      4'b1101: condHolds = flags_q[2] || (flags_q[3] != flags_q[0]);
      default: condHolds = 1'b1;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (br_type)
      2'b00:   taken = 1'b1;
      2'b01:   taken = zero_in;
      2'b10:   taken = !zero_in;
      default: taken = condHolds;
    endcase
  end

  // Next state, counter and registered-output values
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    pcNext    = redirect_pc;
    case (state)
      Idle: begin
        if (br_valid && taken) begin
          stateNext = Redirect;
          pcNext    = br_target;
        end
      end
      Redirect: begin
        if (redirect_ready) begin
          if (FLUSH_CYCLES == 0) begin
            stateNext = Idle;
          end else begin
            stateNext = Flush;
            cntNext   = CntW'(FLUSH_CYCLES);
          end
        end
      end
      Flush: begin
        if (cnt <= CntW'(1)) begin
          stateNext = Idle;
          cntNext   = '0;
        end else begin
          cntNext = cnt - CntW'(1);
        end
      end
      default: begin
        stateNext = Idle;
        cntNext   = '0;
      end
    endcase
    validNext = (stateNext == Redirect);
    stallNext = (stateNext == Redirect);
    flushNext = (stateNext != Idle);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= Idle;
      cnt            <= '0;
      redirect_pc    <= '0;
      redirect_valid <= 1'b0;
      flush          <= 1'b0;
      stall          <= 1'b0;
    end else begin
      state          <= stateNext;
      cnt            <= cntNext;
      redirect_pc    <= pcNext;
      redirect_valid <= validNext;
      flush          <= flushNext;
      stall          <= stallNext;
    end
  end

  // Flag latch runs independently of the redirect FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= 4'b0000;
    end else if (set_flags) begin
      flags_q <= {neg_in, zero_in, carry_in, ovf_in};
    end
  end

endmodule
